// File: rtl/class_arbiter_pkg.sv
// rtl/class_arbiter_pkg.sv - shared state encodings and default sizes for the class arbiter
package class_arbiter_pkg;

    localparam int DEFAULT_DATA_SIZE = 10;
    localparam int DEFAULT_WEIGHT    = 3;
    localparam int DEFAULT_CNT_SIZE  = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        GRANT0 = 2'b01,
        GRANT1 = 2'b10
    } arb_state_e;

endpackage

// File: rtl/class_arbiter_if.sv
// rtl/class_arbiter_if.sv - class FIFO read side, downstream output and status bundle
interface class_arbiter_if
    import class_arbiter_pkg::*;
#(
    parameter int DATA_SIZE = DEFAULT_DATA_SIZE,
    parameter int CNT_SIZE  = DEFAULT_CNT_SIZE
) ();

    logic                 fifo0_empty;
    logic                 fifo1_empty;
    logic [DATA_SIZE-1:0] data0;
    logic [DATA_SIZE-1:0] data1;
    logic                 out_pause;
    logic                 pop0;
    logic                 pop1;
    logic [DATA_SIZE-1:0] out;
    logic                 valid;
    logic                 out_class;
    logic [CNT_SIZE-1:0]  cnt0;
    logic [CNT_SIZE-1:0]  cnt1;
    logic                 idle;

    modport master (
        input  fifo0_empty, fifo1_empty, data0, data1, out_pause,
        output pop0, pop1, out, valid, out_class, cnt0, cnt1, idle
    );

    modport slave (
        output fifo0_empty, fifo1_empty, data0, data1, out_pause,
        input  pop0, pop1, out, valid, out_class, cnt0, cnt1, idle
    );

endinterface

// File: rtl/class_counter.sv
// rtl/class_counter.sv - enabled free-running counter wrapping modulo 2^CNT_SIZE
module class_counter
    import class_arbiter_pkg::*;
#(
    parameter int CNT_SIZE = DEFAULT_CNT_SIZE
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en_i,
    output logic [CNT_SIZE-1:0] cnt_o
);

    logic [CNT_SIZE-1:0] cnt_q;
    logic [CNT_SIZE-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (en_i) begin
            cnt_d = cnt_q + CNT_SIZE'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/class_arbiter.sv
// rtl/class_arbiter.sv - weighted two-class arbiter popping class FIFOs into one output stream
module class_arbiter
    import class_arbiter_pkg::*;
#(
    parameter int DATA_SIZE = DEFAULT_DATA_SIZE,
    parameter int WEIGHT    = DEFAULT_WEIGHT,
    parameter int CNT_SIZE  = DEFAULT_CNT_SIZE
) (
    input logic              clk,
    input logic              reset,
    class_arbiter_if.master  bus
);

    localparam int STREAK_W = (WEIGHT < 1) ? 1 : $clog2(WEIGHT + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(WEIGHT);

    arb_state_e           state_q, state_d;
    logic [STREAK_W-1:0]  streak_q, streak_d;
    logic                 pend_q;
    logic                 pend_cls_q;
    logic [DATA_SIZE-1:0] last_q;
    logic [DATA_SIZE-1:0] out_w;
    logic                 pop0_w, pop1_w;
    logic                 en0_w, en1_w;
    logic [CNT_SIZE-1:0]  cnt0_w, cnt1_w;

    // The empty flags lag this cycle's pop, so the grant is gated again by the live flag.
    assign pop0_w = (state_q == GRANT0) && !bus.fifo0_empty;
    assign pop1_w = (state_q == GRANT1) && !bus.fifo1_empty;

    always_comb begin
        state_d  = IDLE;
        streak_d = streak_q;
        if (bus.out_pause) begin
            state_d = IDLE;
        end else if (!bus.fifo0_empty && !bus.fifo1_empty) begin
            state_d = (streak_q == STREAK_MAX) ? GRANT0 : GRANT1;
        end else if (!bus.fifo0_empty) begin
            state_d = GRANT0;
        end else if (!bus.fifo1_empty) begin
            state_d = GRANT1;
        end

        if (bus.fifo0_empty || state_d == GRANT0) begin
            streak_d = '0;
        end else if (state_d == GRANT1 && streak_q != STREAK_MAX) begin
            streak_d = streak_q + STREAK_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            streak_q   <= '0;
            pend_q     <= 1'b0;
            pend_cls_q <= 1'b0;
            last_q     <= '0;
        end else begin
            state_q  <= state_d;
            streak_q <= streak_d;
            pend_q   <= pop0_w | pop1_w;
            if (pop0_w | pop1_w) begin
                pend_cls_q <= pop1_w;
            end
            last_q <= out_w;
        end
    end

    // FIFO read data arrives the cycle after the pop and is forwarded untouched.
    assign out_w = pend_q ? (pend_cls_q ? bus.data1 : bus.data0) : last_q;

    assign en0_w = pend_q && !pend_cls_q;
    assign en1_w = pend_q && pend_cls_q;

    class_counter #(.CNT_SIZE(CNT_SIZE)) u_cnt0 (
        .clk   (clk),
        .reset (reset),
        .en_i  (en0_w),
        .cnt_o (cnt0_w)
    );

    class_counter #(.CNT_SIZE(CNT_SIZE)) u_cnt1 (
        .clk   (clk),
        .reset (reset),
        .en_i  (en1_w),
        .cnt_o (cnt1_w)
    );

    assign bus.pop0      = pop0_w;
    assign bus.pop1      = pop1_w;
    assign bus.out       = out_w;
    assign bus.valid     = pend_q;
    assign bus.out_class = pend_cls_q;
    assign bus.cnt0      = cnt0_w;
    assign bus.cnt1      = cnt1_w;
    assign bus.idle      = (state_q == IDLE);

endmodule

// File: tb/tb_class_arbiter.sv
// tb/tb_class_arbiter.sv - scoreboard bench for class_arbiter with modelled upstream FIFOs
module tb_class_arbiter;

    localparam int DW = 10;
    localparam int CW = 8;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    class_arbiter_if #(.DATA_SIZE(DW), .CNT_SIZE(CW)) bus ();

    class_arbiter #(.DATA_SIZE(DW), .WEIGHT(3), .CNT_SIZE(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        string       name;
        logic [31:0] act;
        logic [31:0] exp;
    } chk_t;

    typedef struct {
        logic [DW-1:0] word;
        logic          cls;
    } word_t;

    chk_t          chk_q[$];
    word_t         exp_q[$];
    logic [DW-1:0] q0[$];
    logic [DW-1:0] q1[$];

    int   n_vec  = 0;
    int   n_miss = 0;
    logic err0 = 1'b0, err1 = 1'b0, both_err = 1'b0;
    logic lp0 = 1'b0, lp1 = 1'b0;
    int   n_pop0, n_pop1, run1, max_run1, guard;
    logic [15:0] gvec;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_t c;
        c.name = name;
        c.act  = act;
        c.exp  = exp;
        chk_q.push_back(c);
    endtask

    task automatic expect_word(input logic [DW-1:0] w, input logic cls);
        word_t e;
        e.word = w;
        e.cls  = cls;
        exp_q.push_back(e);
    endtask

    task automatic clear_stats();
        n_pop0 = 0; n_pop1 = 0; run1 = 0; max_run1 = 0; gvec = '0;
        lp0 = 1'b0; lp1 = 1'b0;
    endtask

    // One clock: sample pops mid-cycle, then model registered FIFO empty/data after the edge.
    task automatic tick();
        logic p0, p1;
        @(negedge clk);
        p0 = bus.pop0;
        p1 = bus.pop1;
        @(posedge clk);
        #1;
        lp0 = (p0 === 1'b1);
        lp1 = (p1 === 1'b1);
        if (lp0 && lp1) both_err = 1'b1;
        if (lp0) begin
            if (q0.size() == 0) err0 = 1'b1;
            else bus.data0 = q0.pop_front();
            n_pop0++;
            gvec = {gvec[14:0], 1'b0};
        end
        if (lp1) begin
            if (q1.size() == 0) err1 = 1'b1;
            else bus.data1 = q1.pop_front();
            n_pop1++;
            gvec = {gvec[14:0], 1'b1};
            run1++;
            if (run1 > max_run1) max_run1 = run1;
        end else begin
            run1 = 0;
        end
        bus.fifo0_empty = (q0.size() == 0);
        bus.fifo1_empty = (q1.size() == 0);
    endtask

    initial begin : monitor
        chk_t  c;
        word_t e;
        forever begin
            @(negedge clk);
            while (chk_q.size() > 0) begin
                c = chk_q.pop_front();
                n_vec++;
                if (c.act !== c.exp) begin
                    n_miss++;
                    $display("FAIL %s: got %0h, want %0h", c.name, c.act, c.exp);
                end
            end
            if (bus.valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_miss++;
                    $display("FAIL unexpected_word: got out=%0h class=%0d, want no word", bus.out, bus.out_class);
                end else begin
                    e = exp_q.pop_front();
                    n_vec++;
                    if (bus.out !== e.word) begin
                        n_miss++;
                        $display("FAIL out_word: got %0h, want %0h", bus.out, e.word);
                    end
                    n_vec++;
                    if (bus.out_class !== e.cls) begin
                        n_miss++;
                        $display("FAIL out_class: got %0d, want %0d (word %0h)", bus.out_class, e.cls, e.word);
                    end
                end
            end
        end
    end

    initial begin
        bus.fifo0_empty = 1'b1;
        bus.fifo1_empty = 1'b1;
        bus.data0       = '0;
        bus.data1       = '0;
        bus.out_pause   = 1'b0;
        clear_stats();

        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        #1;
        chk("rst_idle",      32'(bus.idle),      32'd1);
        chk("rst_valid",     32'(bus.valid),     32'd0);
        chk("rst_pop0",      32'(bus.pop0),      32'd0);
        chk("rst_pop1",      32'(bus.pop1),      32'd0);
        chk("rst_out",       32'(bus.out),       32'd0);
        chk("rst_out_class", 32'(bus.out_class), 32'd0);
        chk("rst_cnt0",      32'(bus.cnt0),      32'd0);
        chk("rst_cnt1",      32'(bus.cnt1),      32'd0);

        // Only fifo1 holds data.
        clear_stats();
        q1.push_back(10'h3DD); q1.push_back(10'h3CC); q1.push_back(10'h399);
        expect_word(10'h3DD, 1'b1); expect_word(10'h3CC, 1'b1); expect_word(10'h399, 1'b1);
        repeat (10) tick();
        #1;
        chk("t1_pop1_count", 32'(n_pop1),        32'd3);
        chk("t1_pop1_run",   32'(max_run1),      32'd3);
        chk("t1_pop0_count", 32'(n_pop0),        32'd0);
        chk("t1_cnt1",       32'(bus.cnt1),      32'd3);
        chk("t1_cnt0",       32'(bus.cnt0),      32'd0);
        chk("t1_drained",    32'(exp_q.size()),  32'd0);
        chk("t1_err1",       32'(err1),          32'd0);

        // Both FIFOs loaded: weighted order 1,1,1,0,1,1,1,0 then the last class-1 word.
        clear_stats();
        q0.push_back(10'h0FF); q0.push_back(10'h0EE);
        q1.push_back(10'h3DD); q1.push_back(10'h3CC); q1.push_back(10'h3BB); q1.push_back(10'h3AA);
        q1.push_back(10'h399); q1.push_back(10'h388); q1.push_back(10'h377);
        expect_word(10'h3DD, 1'b1); expect_word(10'h3CC, 1'b1); expect_word(10'h3BB, 1'b1);
        expect_word(10'h0FF, 1'b0);
        expect_word(10'h3AA, 1'b1); expect_word(10'h399, 1'b1); expect_word(10'h388, 1'b1);
        expect_word(10'h0EE, 1'b0);
        expect_word(10'h377, 1'b1);
        repeat (14) tick();
        #1;
        chk("t2_grant_order", 32'(gvec[8:0]),    32'h1DD);
        chk("t2_pop0_count",  32'(n_pop0),       32'd2);
        chk("t2_pop1_count",  32'(n_pop1),       32'd7);
        chk("t2_cnt0",        32'(bus.cnt0),     32'd2);
        chk("t2_cnt1",        32'(bus.cnt1),     32'd10);
        chk("t2_drained",     32'(exp_q.size()), 32'd0);
        chk("t2_err",         32'(err0 | err1),  32'd0);

        // Pause raised the cycle after pop0 of 0x0BB.
        clear_stats();
        q0.push_back(10'h0BB); q0.push_back(10'h0CC); q0.push_back(10'h0DD);
        expect_word(10'h0BB, 1'b0); expect_word(10'h0CC, 1'b0); expect_word(10'h0DD, 1'b0);
        guard = 0;
        while (!lp0 && guard < 10) begin
            tick();
            guard++;
        end
        chk("t3_pop0_seen", 32'(lp0), 32'd1);
        bus.out_pause = 1'b1;
        #1;
        chk("t3_valid_in_pause", 32'(bus.valid), 32'd1);
        chk("t3_out_in_pause",   32'(bus.out),   32'h0BB);
        tick();
        clear_stats();
        repeat (5) tick();
        #1;
        chk("t3_paused_pops", 32'(n_pop0 + n_pop1),  32'd0);
        chk("t3_paused_idle", 32'(bus.idle),         32'd1);
        chk("t3_fifo0_held",  32'(bus.fifo0_empty),  32'd0);
        bus.out_pause = 1'b0;
        repeat (6) tick();
        #1;
        chk("t3_cnt0",    32'(bus.cnt0),     32'd5);
        chk("t3_drained", 32'(exp_q.size()), 32'd0);

        // fifo0 runs empty after a single word.
        clear_stats();
        q0.push_back(10'h0AA);
        expect_word(10'h0AA, 1'b0);
        repeat (8) tick();
        #1;
        chk("t4_pop0_count", 32'(n_pop0),       32'd1);
        chk("t4_fifo0_err",  32'(err0),         32'd0);
        chk("t4_cnt0",       32'(bus.cnt0),     32'd6);
        chk("t4_drained",    32'(exp_q.size()), 32'd0);

        // Reset for one edge while a pop is in flight.
        clear_stats();
        q1.push_back(10'h311); q1.push_back(10'h322); q1.push_back(10'h333);
        guard = 0;
        while (bus.pop1 !== 1'b1 && guard < 10) begin
            tick();
            #1;
            guard++;
        end
        chk("t5_pending_pop", 32'(bus.pop1), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        chk("t5_valid", 32'(bus.valid), 32'd0);
        chk("t5_cnt0",  32'(bus.cnt0),  32'd0);
        chk("t5_cnt1",  32'(bus.cnt1),  32'd0);
        chk("t5_idle",  32'(bus.idle),  32'd1);
        chk("t5_pop1",  32'(bus.pop1),  32'd0);
        expect_word(10'h322, 1'b1); expect_word(10'h333, 1'b1);
        repeat (8) tick();
        #1;
        chk("t5_cnt1_after", 32'(bus.cnt1),     32'd2);
        chk("t5_drained",    32'(exp_q.size()), 32'd0);

        // 256 class-0 words wrap cnt0.
        clear_stats();
        for (int i = 0; i < 256; i++) begin
            q0.push_back(DW'(i));
            expect_word(DW'(i), 1'b0);
        end
        repeat (270) tick();
        #1;
        chk("t6_cnt0_wrap",  32'(bus.cnt0),     32'd0);
        chk("t6_cnt1",       32'(bus.cnt1),     32'd2);
        chk("t6_pop0_count", 32'(n_pop0),       32'd256);
        chk("t6_fifo0_err",  32'(err0),         32'd0);
        chk("t6_drained",    32'(exp_q.size()), 32'd0);
        chk("pops_exclusive", 32'(both_err),    32'd0);

        repeat (2) @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
